// File: rtl/system_0_sysid_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : system_0_sysid_checker
// Brief   : Avalon-MM read master that fetches system ID and build timestamp,
//           compares them with expected values, with timeout/retry handling.
// Revision: 1.0 - initial release
// ============================================================================
module system_0_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1766031671,
    parameter int          READ_LATENCY = 0,
    parameter int          TIMEOUT      = 255,
    parameter int          MAX_RETRIES  = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        error,
    output logic [31:0] sys_id,
    output logic [31:0] sys_timestamp
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ_ID = 3'd1,
        S_LAT_ID = 3'd2,
        S_REQ_TS = 3'd3,
        S_LAT_TS = 3'd4,
        S_CHECK  = 3'd5,
        S_FINISH = 3'd6,
        S_FAIL   = 3'd7
    } state_t;

    localparam bit          c_LAT0     = (READ_LATENCY == 0);
    localparam logic [2:0]  c_LAT_LAST = 3'(READ_LATENCY - 1);
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [4:0]  c_MAX_RTY  = 5'(MAX_RETRIES);

    state_t      r_state;
    state_t      w_next;
    logic        r_gap;
    logic [15:0] r_tmo_cnt;
    logic [2:0]  r_lat_cnt;
    logic [4:0]  r_retry;
    logic        r_busy;
    logic        r_done;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_error;
    logic [31:0] r_sys_id;
    logic [31:0] r_sys_ts;

    logic        w_in_req;
    logic        w_accept;
    logic        w_tmo_hit;
    logic        w_lat_last;
    logic        w_start_ok;
    logic [4:0]  w_retry_next;
    logic        w_retry_ok;
    logic        w_cap_id;
    logic        w_cap_ts;

    // r_gap forces one idle cycle on the bus after a timeout abort.
    assign w_in_req     = ((r_state == S_REQ_ID) || (r_state == S_REQ_TS)) && !r_gap;
    assign w_accept     = w_in_req && !avm_waitrequest;
    assign w_tmo_hit    = w_in_req && avm_waitrequest && (r_tmo_cnt == c_TMO_LAST);
    assign w_lat_last   = ((r_state == S_LAT_ID) || (r_state == S_LAT_TS)) && (r_lat_cnt == c_LAT_LAST);
    assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_FINISH) || (r_state == S_FAIL));
    assign w_retry_next = r_retry + 5'd1;
    assign w_retry_ok   = (w_retry_next <= c_MAX_RTY);
    assign w_cap_id     = ((r_state == S_REQ_ID) && w_accept && c_LAT0) || ((r_state == S_LAT_ID) && w_lat_last);
    assign w_cap_ts     = ((r_state == S_REQ_TS) && w_accept && c_LAT0) || ((r_state == S_LAT_TS) && w_lat_last);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FINISH, S_FAIL: if (start) w_next = S_REQ_ID;
            S_REQ_ID: begin
                if (w_tmo_hit)     w_next = w_retry_ok ? S_REQ_ID : S_FAIL;
                else if (w_accept) w_next = c_LAT0 ? S_REQ_TS : S_LAT_ID;
            end
            S_LAT_ID: if (w_lat_last) w_next = S_REQ_TS;
            S_REQ_TS: begin
                if (w_tmo_hit)     w_next = w_retry_ok ? S_REQ_ID : S_FAIL;
                else if (w_accept) w_next = c_LAT0 ? S_CHECK : S_LAT_TS;
            end
            S_LAT_TS: if (w_lat_last) w_next = S_CHECK;
            S_CHECK:  w_next = S_FINISH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_gap     <= 1'b0;
            r_tmo_cnt <= 16'd0;
            r_lat_cnt <= 3'd0;
            r_retry   <= 5'd0;
        end else begin
            r_state   <= w_next;
            r_gap     <= w_tmo_hit && w_retry_ok;
            r_tmo_cnt <= (w_in_req && avm_waitrequest && !w_tmo_hit) ? r_tmo_cnt + 16'd1 : 16'd0;
            r_lat_cnt <= (((r_state == S_LAT_ID) || (r_state == S_LAT_TS)) && !w_lat_last) ?
                         r_lat_cnt + 3'd1 : 3'd0;
            if (w_start_ok)     r_retry <= 5'd0;
            else if (w_tmo_hit) r_retry <= w_retry_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_id_ok  <= 1'b0;
            r_ts_ok  <= 1'b0;
            r_error  <= 1'b0;
            r_sys_id <= 32'd0;
            r_sys_ts <= 32'd0;
        end else begin
            if (w_start_ok) begin
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_id_ok <= 1'b0;
                r_ts_ok <= 1'b0;
                r_error <= 1'b0;
            end else if (r_state == S_CHECK) begin
                r_id_ok <= (r_sys_id == EXPECTED_ID);
                r_ts_ok <= (r_sys_ts == EXPECTED_TS);
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
            end else if (w_tmo_hit && !w_retry_ok) begin
                r_id_ok <= 1'b0;
                r_ts_ok <= 1'b0;
                r_error <= 1'b1;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
            end
            if (w_cap_id) r_sys_id <= avm_readdata;
            if (w_cap_ts) r_sys_ts <= avm_readdata;
        end
    end

    assign avm_read      = w_in_req;
    assign avm_address   = (r_state == S_REQ_TS);
    assign busy          = r_busy;
    assign done          = r_done;
    assign id_ok         = r_id_ok;
    assign ts_ok         = r_ts_ok;
    assign error         = r_error;
    assign sys_id        = r_sys_id;
    assign sys_timestamp = r_sys_ts;

endmodule
`default_nettype wire

// File: tb/tb_system_0_sysid_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_system_0_sysid_checker
// Brief   : Scoreboard bench: two checker instances (latency 0 and 2) with
//           behavioural Avalon slaves; a monitor checks each done event.
// Revision: 1.0 - initial release
// ============================================================================
module tb_system_0_sysid_checker;

    localparam logic [31:0] EXP_TS = 32'd1766031671;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        err;
        logic [31:0] sid;
        logic [31:0] sts;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        start_a, addr_a, read_a, wait_a, busy_a, done_a, idok_a, tsok_a, err_a;
    logic [31:0] rdata_a, sid_a, sts_a;
    logic        start_b, addr_b, read_b, wait_b, busy_b, done_b, idok_b, tsok_b, err_b;
    logic [31:0] rdata_b, sid_b, sts_b;

    logic [31:0] wd0, wd1;
    logic        stuck_a;
    int          stall_b;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t qa[$];
    exp_t qb[$];

    // Slave A: zero latency, waitrequest held high only when stuck.
    assign wait_a  = stuck_a;
    assign rdata_a = addr_a ? wd1 : wd0;

    // Slave B: stall_b wait states per read, data valid 2 cycles after acceptance.
    int   scnt_b;
    logic p1v, p1a, p2v, p2a;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scnt_b <= 0; p1v <= 1'b0; p1a <= 1'b0; p2v <= 1'b0; p2a <= 1'b0;
        end else begin
            scnt_b <= (read_b && wait_b) ? scnt_b + 1 : 0;
            p1v    <= read_b && !wait_b;
            p1a    <= addr_b;
            p2v    <= p1v;
            p2a    <= p1a;
        end
    end
    assign wait_b  = read_b && (scnt_b < stall_b);
    assign rdata_b = p2v ? (p2a ? wd1 : wd0) : 32'hDEAD_BEEF;

    system_0_sysid_checker #(.READ_LATENCY(0), .TIMEOUT(8), .MAX_RETRIES(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a),
        .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wait_a), .avm_readdata(rdata_a),
        .busy(busy_a), .done(done_a), .id_ok(idok_a), .ts_ok(tsok_a), .error(err_a),
        .sys_id(sid_a), .sys_timestamp(sts_a)
    );

    system_0_sysid_checker #(.READ_LATENCY(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b),
        .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wait_b), .avm_readdata(rdata_b),
        .busy(busy_b), .done(done_b), .id_ok(idok_b), .ts_ok(tsok_b), .error(err_b),
        .sys_id(sid_b), .sys_timestamp(sts_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic compare_exp(input string tag, input exp_t e, input logic idok, input logic tsok,
                               input logic err, input logic busy, input logic [31:0] sid,
                               input logic [31:0] sts, input int lat);
        check({tag, " id_ok"},   64'(idok), 64'(e.id_ok));
        check({tag, " ts_ok"},   64'(tsok), 64'(e.ts_ok));
        check({tag, " error"},   64'(err),  64'(e.err));
        check({tag, " busy"},    64'(busy), 64'd0);
        check({tag, " sys_id"},  64'(sid),  64'(e.sid));
        check({tag, " sys_ts"},  64'(sts),  64'(e.sts));
        check({tag, " latency"}, 64'(lat),  64'(e.lat));
    endtask

    function automatic exp_t mk(input logic i, input logic t, input logic er,
                                input logic [31:0] s0, input logic [31:0] s1, input int l);
        exp_t e;
        e.id_ok = i; e.ts_ok = t; e.err = er; e.sid = s0; e.sts = s1; e.lat = l;
        return e;
    endfunction

    // Monitors: latency counted in cycles from the accepted start cycle.
    int   cnt_a, cnt_b;
    logic pdone_a, pdone_b;
    exp_t ea, eb;

    always @(negedge clock) begin
        if (!reset_n) begin
            cnt_a = 0; pdone_a = 1'b0;
        end else begin
            if (start_a && !busy_a) cnt_a = 0;
            else cnt_a++;
            if (done_a && !pdone_a) begin
                if (qa.size() == 0) check("A unexpected done", 64'd1, 64'd0);
                else begin
                    ea = qa.pop_front();
                    compare_exp("A", ea, idok_a, tsok_a, err_a, busy_a, sid_a, sts_a, cnt_a);
                end
            end
            pdone_a = done_a;
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            cnt_b = 0; pdone_b = 1'b0;
        end else begin
            if (start_b && !busy_b) cnt_b = 0;
            else cnt_b++;
            if (done_b && !pdone_b) begin
                if (qb.size() == 0) check("B unexpected done", 64'd1, 64'd0);
                else begin
                    eb = qb.pop_front();
                    compare_exp("B", eb, idok_b, tsok_b, err_b, busy_b, sid_b, sts_b, cnt_b);
                end
            end
            pdone_b = done_b;
        end
    end

    // Address and read strobe must hold through every stalled cycle.
    logic pstall_b, paddr_b;
    always @(negedge clock) begin
        if (!reset_n) begin
            pstall_b = 1'b0; paddr_b = 1'b0;
        end else begin
            if (pstall_b) begin
                check("B read held in stall", 64'(read_b), 64'd1);
                check("B addr held in stall", 64'(addr_b), 64'(paddr_b));
            end
            pstall_b = read_b && wait_b;
            paddr_b  = addr_b;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_a();
        start_a = 1'b1; tick(); start_a = 1'b0;
    endtask

    task automatic pulse_b();
        start_b = 1'b1; tick(); start_b = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin tick(); n++; end
        if (!done_a) check("A done wait expired", 64'd0, 64'd1);
        repeat (2) tick();
    endtask

    task automatic wait_done_b(input int budget);
        int n = 0;
        while (!done_b && n < budget) begin tick(); n++; end
        if (!done_b) check("B done wait expired", 64'd0, 64'd1);
        repeat (2) tick();
    endtask

    initial begin
        logic [17:0] pat;
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        wd0 = 32'd0; wd1 = EXP_TS; stuck_a = 1'b0; stall_b = 0;
        repeat (2) @(posedge clock);
        #1;
        check("A reset flags", 64'({busy_a, done_a, idok_a, tsok_a, err_a, read_a, addr_a}), 64'd0);
        check("A reset data",  {sid_a, sts_a}, 64'd0);
        check("B reset flags", 64'({busy_b, done_b, idok_b, tsok_b, err_b, read_b, addr_b}), 64'd0);
        check("B reset data",  {sid_b, sts_b}, 64'd0);
        reset_n = 1'b1;
        tick();

        // Zero-wait, zero-latency pass: ID then TS on consecutive cycles.
        qa.push_back(mk(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, 4));
        pulse_a();
        check("A cycle1 read/addr", 64'({read_a, addr_a}), 64'b10);
        tick();
        check("A cycle2 read/addr", 64'({read_a, addr_a}), 64'b11);
        tick();
        check("A cycle3 read/addr", 64'({read_a, addr_a}), 64'b00);
        wait_done_a(10);

        // Timestamp mismatch.
        wd1 = 32'h1234_5678;
        qa.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, 32'h1234_5678, 4));
        pulse_a();
        wait_done_a(10);

        // Start while busy ignored; start held in FINISH reruns and clears flags.
        wd1 = EXP_TS;
        qa.push_back(mk(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, 4));
        pulse_a();
        tick();
        pulse_a();
        wait_done_a(10);
        wd1 = 32'h1234_5678;
        qa.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, 32'h1234_5678, 4));
        pulse_a();
        check("A restart clears flags", 64'({done_a, idok_a, tsok_a, err_a, busy_a}), 64'b00001);
        wait_done_a(10);

        // Stuck waitrequest: two 8-cycle attempts, each followed by a read gap.
        stuck_a = 1'b1;
        qa.push_back(mk(1'b0, 1'b0, 1'b1, 32'd0, 32'h1234_5678, 18));
        pulse_a();
        for (int i = 0; i < 18; i++) begin
            pat[i] = read_a;
            tick();
        end
        check("A timeout read pattern", 64'(pat), 64'h1FEFF);
        check("A fail flags", 64'({done_a, err_a, busy_a}), 64'b110);
        repeat (2) tick();

        // Restart from FAIL with a healthy slave.
        stuck_a = 1'b0;
        wd1 = EXP_TS;
        qa.push_back(mk(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, 4));
        pulse_a();
        wait_done_a(10);

        // Latency 2 with 5 wait states per read.
        stall_b = 5;
        qb.push_back(mk(1'b1, 1'b1, 1'b0, 32'd0, EXP_TS, 18));
        pulse_b();
        wait_done_b(40);

        // Reset during LAT_TS clears everything at once.
        stall_b = 0;
        wd1 = 32'hA5A5_0001;
        pulse_b();
        repeat (4) tick();
        check("B mid-run busy/read", 64'({busy_b, read_b}), 64'b10);
        reset_n = 1'b0;
        #1;
        check("B async reset flags", 64'({busy_b, done_b, idok_b, tsok_b, err_b, read_b, addr_b}), 64'd0);
        check("B async reset data",  {sid_b, sts_b}, 64'd0);
        check("A async reset data",  {sid_a, sts_a}, 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Normal run after reset, timestamp mismatch.
        qb.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, 32'hA5A5_0001, 8));
        pulse_b();
        wait_done_b(20);

        check("A queue drained", 64'(qa.size()), 64'd0);
        check("B queue drained", 64'(qb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
